// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's two arithmetic writeback ports among four
// writeback sources: 0 = arith lane A, 1 = arith lane B, 2 = load/store lane A,
// 3 = load/store lane B. Each source has its own small FIFO. A round-robin
// scheduler drains up to two FIFO heads per cycle onto write ports A and B. It
// never issues two writes to the same register in one cycle.
//
// Optional feature macro: WB_STATS_EN
//   When defined, conflicts_o counts cycles in which at least one head was
//   deferred because its address matched port A's. The count saturates at
//   16'hFFFF. When undefined, conflicts_o is tied to zero. Arbitration is the
//   same in both builds.
//
// Ports
//   clock_i      in   1          rising-edge clock
//   reset_i      in   1          asynchronous, active-low reset
//   req_i        in   4          writeback request per source
//   addr_i       in   4*ADDR_W   dest register, source n at [n*ADDR_W +: ADDR_W]
//   data_i       in   4*DATA_W   writeback value, same packing
//   status_i     in   8          operationStatus, 2 bits per source
//                                (sources 2 and 3 store 2'b00)
//   full_o       out  4          registered almost-full (count >= DEPTH-1)
//   overflow_o   out  1          sticky: a request was dropped
//   weA_o / addrA_o / datA_o / statusA_o   write port A
//   weB_o / addrB_o / datB_o / statusB_o   write port B
//   conflicts_o  out  16         same-address deferral cycle counter
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [3:0]            req_i,
    input  logic [4*ADDR_W-1:0]   addr_i,
    input  logic [4*DATA_W-1:0]   data_i,
    input  logic [7:0]            status_i,
    output logic [3:0]            full_o,
    output logic                  overflow_o,
    output logic                  weA_o,
    output logic [ADDR_W-1:0]     addrA_o,
    output logic [DATA_W-1:0]     datA_o,
    output logic [1:0]            statusA_o,
    output logic                  weB_o,
    output logic [ADDR_W-1:0]     addrB_o,
    output logic [DATA_W-1:0]     datB_o,
    output logic [1:0]            statusB_o,
    output logic [15:0]           conflicts_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W + 2;

    logic [3:0]        headValid;
    logic [3:0]        pushOk;
    logic [3:0]        pop;
    logic [ADDR_W-1:0] headAddr   [4];
    logic [DATA_W-1:0] headData   [4];
    logic [1:0]        headStatus [4];

    logic [1:0] rrReg, rrNext;
    logic       grantA, grantB;
    logic [1:0] srcA, srcB, scanSrc;
`ifdef WB_STATS_EN
    logic       deferred;
`endif

    // ---------------------------------------------------------------- FIFOs
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
            logic [CNT_W-1:0] countReg, countNext;
            logic             fullReg;
            logic [1:0]       pushStatus;
            logic [ENT_W-1:0] headEntry;

            // Load/store lanes carry no operationStatus.
            assign pushStatus = (gi < 2) ? status_i[2*gi +: 2] : 2'b00;

            // A full FIFO still accepts a push when its head leaves this cycle.
            assign pushOk[gi] = req_i[gi] &&
                                ((countReg != CNT_W'(DEPTH)) || pop[gi]);
            assign countNext  = countReg + CNT_W'(pushOk[gi]) - CNT_W'(pop[gi]);

            assign headEntry      = mem[rdPtrReg];
            assign headValid[gi]  = (countReg != '0);
            assign headAddr[gi]   = headEntry[ENT_W-1 -: ADDR_W];
            assign headData[gi]   = headEntry[DATA_W+1 : 2];
            assign headStatus[gi] = headEntry[1:0];
            assign full_o[gi]     = fullReg;

            // Storage carries no reset: only count/pointers define validity.
            always_ff @(posedge clock_i) begin
                if (pushOk[gi]) begin
                    mem[wrPtrReg] <= {addr_i[gi*ADDR_W +: ADDR_W],
                                      data_i[gi*DATA_W +: DATA_W], pushStatus};
                end
            end

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    wrPtrReg <= '0;
                    rdPtrReg <= '0;
                    countReg <= '0;
                    fullReg  <= 1'b0;
                end else begin
                    if (pushOk[gi]) wrPtrReg <= wrPtrReg + 1'b1;
                    if (pop[gi])    rdPtrReg <= rdPtrReg + 1'b1;
                    countReg <= countNext;
                    // Flag from the next count, so full_o tracks the stored count.
                    fullReg  <= (countNext >= CNT_W'(DEPTH - 1));
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------ scheduler
    // Scan rr, rr+1, rr+2, rr+3. The first valid head takes port A. The next
    // valid head with a different address takes port B. Same-address heads in
    // between are deferred and stay queued.
    always_comb begin
        grantA  = 1'b0;
        grantB  = 1'b0;
        srcA    = 2'd0;
        srcB    = 2'd0;
        scanSrc = 2'd0;
        pop     = 4'b0000;
`ifdef WB_STATS_EN
        deferred = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            scanSrc = rrReg + 2'(k);
            if (headValid[scanSrc]) begin
                if (!grantA) begin
                    grantA = 1'b1;
                    srcA   = scanSrc;
                end else if (!grantB) begin
                    if (headAddr[scanSrc] != headAddr[srcA]) begin
                        grantB = 1'b1;
                        srcB   = scanSrc;
                    end
`ifdef WB_STATS_EN
                    else begin
                        deferred = 1'b1;
                    end
`endif
                end
            end
        end
        if (grantA) pop[srcA] = 1'b1;
        if (grantB) pop[srcB] = 1'b1;

        rrNext = rrReg;
        if (grantB)      rrNext = srcB + 2'd1;
        else if (grantA) rrNext = srcA + 2'd1;
    end

    // ------------------------------------------------------- output registers
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rrReg      <= 2'd0;
            overflow_o <= 1'b0;
            weA_o      <= 1'b0;
            addrA_o    <= '0;
            datA_o     <= '0;
            statusA_o  <= 2'b00;
            weB_o      <= 1'b0;
            addrB_o    <= '0;
            datB_o     <= '0;
            statusB_o  <= 2'b00;
        end else begin
            rrReg <= rrNext;
            if (|(req_i & ~pushOk)) overflow_o <= 1'b1;
            weA_o <= grantA;
            weB_o <= grantB;
            // An idle port keeps its last address/data/status.
            if (grantA) begin
                addrA_o   <= headAddr[srcA];
                datA_o    <= headData[srcA];
                statusA_o <= headStatus[srcA];
            end
            if (grantB) begin
                addrB_o   <= headAddr[srcB];
                datB_o    <= headData[srcB];
                statusB_o <= headStatus[srcB];
            end
        end
    end

`ifdef WB_STATS_EN
    logic [15:0] conflictsReg;
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            conflictsReg <= 16'd0;
        end else if (deferred && (conflictsReg != 16'hFFFF)) begin
            conflictsReg <= conflictsReg + 16'd1;
        end
    end
    assign conflicts_o = conflictsReg;
`else
    assign conflicts_o = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic                clock_i = 1'b0;
    logic                reset_i;
    logic [3:0]          req_i;
    logic [4*ADDR_W-1:0] addr_i;
    logic [4*DATA_W-1:0] data_i;
    logic [7:0]          status_i;
    logic [3:0]          full_o;
    logic                overflow_o;
    logic                weA_o, weB_o;
    logic [ADDR_W-1:0]   addrA_o, addrB_o;
    logic [DATA_W-1:0]   datA_o, datB_o;
    logic [1:0]          statusA_o, statusB_o;
    logic [15:0]         conflicts_o;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .addr_i(addr_i),
        .data_i(data_i), .status_i(status_i), .full_o(full_o),
        .overflow_o(overflow_o), .weA_o(weA_o), .addrA_o(addrA_o),
        .datA_o(datA_o), .statusA_o(statusA_o), .weB_o(weB_o),
        .addrB_o(addrB_o), .datB_o(datB_o), .statusB_o(statusB_o),
        .conflicts_o(conflicts_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------ behavioural reference
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [1:0]        s;
    } ent_t;

    ent_t              mq [4][$];
    int                mrr;
    logic              eWeA, eWeB, eOvf;
    logic [ADDR_W-1:0] eAddrA, eAddrB;
    logic [DATA_W-1:0] eDatA, eDatB;
    logic [1:0]        eStA, eStB;
    logic [3:0]        eFull;
    logic [15:0]       eConf;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) mq[n].delete();
        mrr = 0; eWeA = 0; eWeB = 0; eOvf = 0;
        eAddrA = '0; eAddrB = '0; eDatA = '0; eDatB = '0;
        eStA = '0; eStB = '0; eFull = '0; eConf = '0;
    endtask

    // One clock edge of the arbiter, computed from queues.
    task automatic model_step();
        bit gA = 0, gB = 0, def = 0;
        int sA = 0, sB = 0;
        ent_t e;
        for (int k = 0; k < 4; k++) begin
            int s = (mrr + k) % 4;
            if (mq[s].size() == 0) continue;
            if (!gA) begin gA = 1; sA = s; end
            else if (!gB) begin
                if (mq[s][0].a != mq[sA][0].a) begin gB = 1; sB = s; end
                else def = 1;
            end
        end
        eWeA = gA; eWeB = gB;
        if (gA) begin e = mq[sA][0]; eAddrA = e.a; eDatA = e.d; eStA = e.s; end
        if (gB) begin e = mq[sB][0]; eAddrB = e.a; eDatB = e.d; eStB = e.s; end
        if (gB) mrr = (sB + 1) % 4; else if (gA) mrr = (sA + 1) % 4;
        if (gA) void'(mq[sA].pop_front());
        if (gB) void'(mq[sB].pop_front());
        for (int n = 0; n < 4; n++) begin
            if (req_i[n]) begin
                if (mq[n].size() < DEPTH) begin
                    e.a = addr_i[n*ADDR_W +: ADDR_W];
                    e.d = data_i[n*DATA_W +: DATA_W];
                    e.s = (n < 2) ? status_i[2*n +: 2] : 2'b00;
                    mq[n].push_back(e);
                end else eOvf = 1;
            end
        end
        for (int n = 0; n < 4; n++) eFull[n] = (mq[n].size() >= DEPTH - 1);
`ifdef WB_STATS_EN
        if (def && eConf != 16'hFFFF) eConf = eConf + 16'd1;
`endif
    endtask

    task automatic cycle();
        if (!reset_i) model_reset(); else model_step();
        @(posedge clock_i); #1;
    endtask

    task automatic set_src(input int n, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [1:0] s);
        req_i[n] = 1'b1;
        addr_i[n*ADDR_W +: ADDR_W] = a;
        data_i[n*DATA_W +: DATA_W] = d;
        status_i[2*n +: 2] = s;
    endtask

    task automatic do_reset();
        req_i = '0;
        reset_i = 1'b0;
        model_reset();
        @(posedge clock_i); #1;
        reset_i = 1'b1;
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        req_i = '0; addr_i = '0; data_i = '0; status_i = '0;
        reset_i = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({weA_o, weB_o, full_o, overflow_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags: got we=%b%b full=%b ovf=%b, want all 0",
                     weA_o, weB_o, full_o, overflow_o);
        end
        checks++;
        if ({addrA_o, datA_o, statusA_o, addrB_o, datB_o, statusB_o, conflicts_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got A=%h/%h/%h B=%h/%h/%h conf=%h, want 0",
                     addrA_o, datA_o, statusA_o, addrB_o, datB_o, statusB_o, conflicts_o);
        end
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        set_src(0, 5'd3, 16'h00AA, 2'd2);
        cycle();
        req_i = '0;
        checks++;
        if (weA_o !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: weA=%b want 0", weA_o);
        end
        cycle();
        checks++;
        if ({weA_o, addrA_o, datA_o, statusA_o, weB_o} !== {1'b1, 5'd3, 16'h00AA, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got weA=%b addr=%0d dat=%h st=%0d weB=%b, want 1 3 00aa 2 0",
                     weA_o, addrA_o, datA_o, statusA_o, weB_o);
        end
        $display("test_single done");
    endtask

    task automatic test_all_four();
        do_reset();
        status_i = 8'hFF;
        for (int n = 0; n < 4; n++) set_src(n, 5'(n + 1), 16'hA0 + 16'(n), 2'(n + 1));
        cycle();
        req_i = '0;
        cycle();
        checks++;
        if ({weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o} !==
            {1'b1, 5'd1, 16'hA0, 2'd1, 1'b1, 5'd2, 16'hA1, 2'd2}) begin
            errors++;
            $display("FAIL all4_cycle1: got A=%b/%0d/%h/%0d B=%b/%0d/%h/%0d, want A=src0 B=src1",
                     weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o);
        end
        cycle();
        checks++;
        if ({weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o} !==
            {1'b1, 5'd3, 16'hA2, 2'd0, 1'b1, 5'd4, 16'hA3, 2'd0}) begin
            errors++;
            $display("FAIL all4_cycle2: got A=%b/%0d/%h/%0d B=%b/%0d/%h/%0d, want A=src2 B=src3 st 0",
                     weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o);
        end
        cycle();
        checks++;
        if ({weA_o, weB_o} !== 2'b00) begin
            errors++;
            $display("FAIL all4_idle: got we=%b%b want 00", weA_o, weB_o);
        end
        // rr is back at 0: src0 must win port A over src1.
        set_src(1, 5'd9, 16'hB1, 2'd0);
        set_src(0, 5'd8, 16'hB0, 2'd0);
        cycle();
        req_i = '0;
        cycle();
        checks++;
        if ({addrA_o, addrB_o} !== {5'd8, 5'd9}) begin
            errors++;
            $display("FAIL all4_rr_zero: got addrA=%0d addrB=%0d want 8 9", addrA_o, addrB_o);
        end
        $display("test_all_four done");
    endtask

    task automatic test_same_addr();
        logic [15:0] wantConf;
`ifdef WB_STATS_EN
        wantConf = 16'd1;
`else
        wantConf = 16'd0;
`endif
        do_reset();
        set_src(0, 5'd7, 16'h1111, 2'd1);
        set_src(2, 5'd7, 16'h2222, 2'd0);
        cycle();
        req_i = '0;
        cycle();
        checks++;
        if ({weA_o, datA_o, weB_o} !== {1'b1, 16'h1111, 1'b0}) begin
            errors++;
            $display("FAIL same_addr_first: got weA=%b datA=%h weB=%b want 1 1111 0",
                     weA_o, datA_o, weB_o);
        end
        checks++;
        if (conflicts_o !== wantConf) begin
            errors++;
            $display("FAIL same_addr_conflicts: got %0d want %0d", conflicts_o, wantConf);
        end
        cycle();
        checks++;
        if ({weA_o, addrA_o, datA_o, weB_o} !== {1'b1, 5'd7, 16'h2222, 1'b0}) begin
            errors++;
            $display("FAIL same_addr_second: got weA=%b addrA=%0d datA=%h weB=%b want 1 7 2222 0",
                     weA_o, addrA_o, datA_o, weB_o);
        end
        $display("test_same_addr done");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int n = 0; n < 4; n++) set_src(n, 5'd9, 16'($urandom), 2'($urandom));
            cycle();
            checks++;
            if ({full_o, overflow_o} !== {eFull, eOvf}) begin
                errors++;
                $display("FAIL overflow_fill c=%0d: got full=%b ovf=%b want full=%b ovf=%b",
                         c, full_o, overflow_o, eFull, eOvf);
            end
        end
        checks++;
        if ({overflow_o, full_o[1]} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b full1=%b want 1 1", overflow_o, full_o[1]);
        end
        req_i = '0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            checks++;
            if ({weA_o, addrA_o, datA_o, statusA_o, weB_o, full_o, overflow_o} !==
                {eWeA, eAddrA, eDatA, eStA, eWeB, eFull, eOvf}) begin
                errors++;
                $display("FAIL overflow_drain c=%0d: got we=%b%b dat=%h full=%b ovf=%b want we=%b%b dat=%h full=%b ovf=%b",
                         c, weA_o, weB_o, datA_o, full_o, overflow_o, eWeA, eWeB, eDatA, eFull, eOvf);
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int n = 0; n < 4; n++) set_src(n, 5'(n), 16'($urandom), 2'($urandom));
            cycle();
        end
        #2;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({weA_o, weB_o, full_o, overflow_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: got we=%b%b full=%b ovf=%b want all 0",
                     weA_o, weB_o, full_o, overflow_o);
        end
        @(posedge clock_i); #1;
        model_reset();
        reset_i = 1'b1;
        cycle();
        checks++;
        if ({weA_o, weB_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_write: got we=%b%b want 00", weA_o, weB_o);
        end
        req_i = '0;
        cycle();
        checks++;
        if ({weA_o, addrA_o, weB_o, addrB_o} !== {eWeA, eAddrA, eWeB, eAddrB}) begin
            errors++;
            $display("FAIL reset_resume: got A=%b/%0d B=%b/%0d want A=%b/%0d B=%b/%0d",
                     weA_o, addrA_o, weB_o, addrB_o, eWeA, eAddrA, eWeB, eAddrB);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_fairness();
        logic [15:0] q0 [$];
        logic [15:0] q3 [$];
        logic [15:0] w0, w3, d;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            d = 16'($urandom); set_src(0, 5'd10, d, 2'd1); q0.push_back(d);
            d = 16'($urandom); set_src(3, 5'd20, d, 2'd3); q3.push_back(d);
            cycle();
            if (i >= 1) begin
                w0 = q0.pop_front();
                w3 = q3.pop_front();
                checks++;
                if ({weA_o, addrA_o, datA_o, weB_o, addrB_o, datB_o} !==
                    {1'b1, 5'd10, w0, 1'b1, 5'd20, w3}) begin
                    errors++;
                    $display("FAIL fairness i=%0d: got A=%b/%0d/%h B=%b/%0d/%h want A=1/10/%h B=1/20/%h",
                             i, weA_o, addrA_o, datA_o, weB_o, addrB_o, datB_o, w0, w3);
                end
            end
        end
        req_i = '0;
        $display("test_fairness done");
    endtask

    task automatic test_random(input int cycles, input int loadPct);
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int n = 0; n < 4; n++) begin
                req_i[n] = ($urandom_range(0, 99) < loadPct);
                addr_i[n*ADDR_W +: ADDR_W] = 5'($urandom_range(0, 3));
                data_i[n*DATA_W +: DATA_W] = 16'($urandom);
            end
            status_i = 8'($urandom);
            cycle();
            checks++;
            if ({weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o} !==
                {eWeA, eAddrA, eDatA, eStA, eWeB, eAddrB, eDatB, eStB}) begin
                errors++;
                $display("FAIL random_ports c=%0d: got A=%b/%0d/%h/%0d B=%b/%0d/%h/%0d want A=%b/%0d/%h/%0d B=%b/%0d/%h/%0d",
                         c, weA_o, addrA_o, datA_o, statusA_o, weB_o, addrB_o, datB_o, statusB_o,
                         eWeA, eAddrA, eDatA, eStA, eWeB, eAddrB, eDatB, eStB);
            end
            checks++;
            if ({full_o, overflow_o, conflicts_o} !== {eFull, eOvf, eConf}) begin
                errors++;
                $display("FAIL random_flags c=%0d: got full=%b ovf=%b conf=%0d want full=%b ovf=%b conf=%0d",
                         c, full_o, overflow_o, conflicts_o, eFull, eOvf, eConf);
            end
        end
        req_i = '0;
        $display("test_random load=%0d%% cycles=%0d done", loadPct, cycles);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_same_addr();
        test_overflow();
        test_reset_mid();
        test_fairness();
        test_random(300, 30);
        test_random(300, 70);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
